// File: rtl/demux8_stream.sv
// demux8_stream: registered 1-to-8 stream demultiplexer with a one-entry holding register per channel.
// Latency: 1 cycle from input accept to out_valid on the addressed channel(s).
// Backpressure: in_ready drops only when the addressed channel (all channels for broadcast) holds a word its consumer is not taking.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   in_valid/in_ready      input handshake; in_data word, in_sel destination 0..7
//   in_bcast               broadcast request, honoured only when DEMUX8_BCAST_EN is defined
//   out_valid/out_ready    per-channel handshake, bit k belongs to channel k
//   out_data               channel k on bits [k*WIDTH +: WIDTH]
//
// Optional feature macro: DEMUX8_BCAST_EN (all-or-nothing broadcast to all 8 channels).
module demux8_stream #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  input  logic               in_bcast,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ready,
  output logic [8*WIDTH-1:0] out_data
);

  logic [7:0]       vld;
  logic [WIDTH-1:0] dat [8];
  logic [7:0]       can_load;
  logic [7:0]       sel_mask;
  logic [7:0]       load;
  logic             bcast;
  logic             ready_raw;
  logic             accept;

  // A channel can take a new word when empty or when its current word leaves this cycle.
  assign can_load = ~vld | out_ready;

`ifdef DEMUX8_BCAST_EN
  assign bcast = in_bcast;
`else
  // Broadcast is compiled out; the port is kept for a uniform footprint.
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast        = 1'b0;
`endif

  always_comb begin
    sel_mask = 8'h00;
    sel_mask[in_sel] = 1'b1;
    if (bcast) begin
      // All-or-nothing: every channel must be able to load or none does.
      ready_raw = &can_load;
    end else begin
      ready_raw = can_load[in_sel];
    end
  end

  // Depends only on registered state, out_ready, in_sel and in_bcast - never on in_valid.
  assign in_ready = ready_raw & ~rst;
  assign accept   = in_valid & in_ready;
  assign load     = accept ? (bcast ? 8'hFF : sel_mask) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        dat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (load[k]) begin
          // Covers drain+load in the same cycle: the new word replaces the old, valid stays set.
          dat[k] <= in_data;
          vld[k] <= 1'b1;
        end else if (out_ready[k]) begin
          // Data is deliberately kept on drain; only the valid flag clears.
          vld[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = vld;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 8; k++) begin
      out_data[k*WIDTH +: WIDTH] = dat[k];
    end
  end

endmodule

// File: tb/tb_demux8_stream.sv
// Testbench for demux8_stream: directed steps from the test plan followed by randomized traffic,
// compared against a per-channel slot model. Works with or without DEMUX8_BCAST_EN.
module tb_demux8_stream;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_sel;
  logic               in_bcast;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a slot that is either empty or holds one word.
  bit         m_full [8];
  logic [31:0] m_word [8];

  demux8_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit bcast_active(input bit b);
`ifdef DEMUX8_BCAST_EN
    return b;
`else
    return 1'b0;
`endif
  endfunction

  // Would the model take a word offered now with these controls?
  function automatic bit model_ready(input bit r, input logic [2:0] s, input bit b,
                                     input logic [7:0] ordy);
    bit ok;
    if (r) return 1'b0;
    if (bcast_active(b)) begin
      ok = 1'b1;
      for (int k = 0; k < 8; k++) if (m_full[k] && !ordy[k]) ok = 1'b0;
      return ok;
    end
    return !m_full[s] || ordy[s];
  endfunction

  // One cycle: drive at the falling edge, check in_ready, advance the model at the rising
  // edge, then check the registered outputs at the next falling edge.
  task automatic step(input bit r, input bit v, input logic [2:0] s, input logic [31:0] d,
                      input bit b, input logic [7:0] ordy);
    bit exp_rdy;
    bit take;
    logic [7:0]   exp_vld;
    logic [255:0] exp_dat;
    rst = r; in_valid = v; in_sel = s; in_data = d; in_bcast = b; out_ready = ordy;
    #1;
    exp_rdy = model_ready(r, s, b, ordy);
    chk("in_ready", {255'd0, in_ready}, {255'd0, exp_rdy});
    take = v && exp_rdy;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (r) begin
        m_full[k] = 1'b0;
        m_word[k] = 32'h0;
      end else if (take && (bcast_active(b) || k == int'(s))) begin
        m_full[k] = 1'b1;
        m_word[k] = d;
      end else if (ordy[k]) begin
        m_full[k] = 1'b0;
      end
    end
    @(negedge clk);
    exp_dat = '0;
    for (int k = 0; k < 8; k++) begin
      exp_vld[k] = m_full[k];
      exp_dat[k*32 +: 32] = m_word[k];
    end
    chk("out_valid", {248'd0, out_valid}, {248'd0, exp_vld});
    chk("out_data", out_data, exp_dat);
  endtask

  initial begin
    logic [7:0] rr;
    for (int k = 0; k < 8; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = 32'h0;
    end
    rst = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; in_bcast = 1'b0; out_ready = 8'h00;
    @(negedge clk);

    // Reset with a word offered: nothing accepted, outputs cleared.
    step(1, 1, 3'd1, 32'hDEAD, 0, 8'h00);
    step(1, 1, 3'd1, 32'hDEAD, 0, 8'h00);
    chk("reset_out_valid", {248'd0, out_valid}, 256'd0);
    chk("reset_out_data", out_data, 256'd0);
    step(0, 0, 3'd0, 32'h0, 0, 8'h00);
    chk("ready_after_reset", {255'd0, in_ready}, 256'd1);

    // Unicast routing to every channel, all consumers ready.
    for (int s = 0; s < 8; s++) begin
      step(0, 1, 3'(s), 32'hA0 + 32'(s), 0, 8'hFF);
      chk("one_hot_valid", 256'($countones(out_valid)), 256'd1);
    end
    step(0, 0, 3'd0, 32'h0, 0, 8'hFF);

    // Backpressure on ch3; ch5 unaffected; release gives a gap-free load.
    step(0, 1, 3'd3, 32'h1111, 0, 8'hF7);
    step(0, 1, 3'd3, 32'h2222, 0, 8'hF7);
    chk("ch3_holds", {224'd0, out_data[3*32 +: 32]}, 256'h1111);
    step(0, 1, 3'd5, 32'h3333, 0, 8'h07);
    step(0, 1, 3'd3, 32'h2222, 0, 8'hFF);
    chk("ch3_reload", {224'd0, out_data[3*32 +: 32]}, 256'h2222);

    // Simultaneous drain and load on ch2.
    step(0, 1, 3'd2, 32'h1234, 0, 8'hFF);
    step(0, 1, 3'd2, 32'hBEEF, 0, 8'hFF);
    chk("ch2_drain_load", {223'd0, out_valid[2], out_data[2*32 +: 32]}, {223'd0, 1'b1, 32'hBEEF});

    // Reset mid-stream with four channels full.
    for (int s = 0; s < 4; s++) step(0, 1, 3'(s), 32'h500 + 32'(s), 0, 8'h00);
    step(1, 1, 3'd4, 32'h777, 0, 8'h00);
    chk("midreset_valid", {248'd0, out_valid}, 256'd0);

    // Broadcast blocked by a stalled ch6, then released.
    step(0, 1, 3'd6, 32'h6666, 0, 8'hBF);
    step(0, 1, 3'd0, 32'hCAFE, 1, 8'hBF);
    step(0, 1, 3'd0, 32'hCAFE, 1, 8'hFF);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rr = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rr = 8'hFF;
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           32'($urandom), ($urandom_range(0, 5) == 0), rr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
